// File: rtl/marvin_timer_pkg.sv
// Shared types and defaults for the countdown timer and any register-map wrapper around it.
package marvin_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2,
    PAUSE  = 2'd3
  } timer_state_t;

  localparam int unsigned TIMER_W_DEFAULT            = 24;
  localparam int unsigned TIMER_PRESCALE_MAX_DEFAULT = 256;

endpackage

// File: rtl/timer_prescaler.sv
// Tick divider for the countdown timer: one tick every div+1 enabled cycles.
// Only built when TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          en,
  input  logic          clr,
  input  logic [PW-1:0] div,
  output logic          tick
);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == div);

  always_ff @(posedge clk) begin
    if (!rst_) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PW'(1);
    end
  end

endmodule
`endif

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with one-shot/periodic modes, pause/resume, expiry pulse and sticky irq.
// Optional tick prescaler enabled by defining TIMER_PRESCALE_EN.
module countdown_timer
  import marvin_timer_pkg::*;
#(
  parameter int unsigned W            = TIMER_W_DEFAULT,
  parameter int unsigned PRESCALE_MAX = TIMER_PRESCALE_MAX_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [W-1:0] load_value,
  input  logic         load_periodic,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  input  logic         irq_ack,
  output logic [W-1:0] remaining,
  output logic         busy,
  output logic         expired,
  output logic         irq
`ifdef TIMER_PRESCALE_EN
  ,
  input  logic [$clog2(PRESCALE_MAX)-1:0] prescale
`endif
);

  timer_state_t state_q, state_d;
  logic [W-1:0] remaining_q, remaining_d;
  logic [W-1:0] reload_q, reload_d;
  logic         periodic_q, periodic_d;
  logic         expired_d;
  logic         irq_d;
  logic         load_acc;
  logic         tick;

  assign load_ready = (state_q != RUN);
  assign load_acc   = load_valid && load_ready;
  assign busy       = (state_q == RUN);
  assign remaining  = remaining_q;

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned PW = $clog2(PRESCALE_MAX);
  logic [PW-1:0] prescale_q;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      prescale_q <= '0;
    end else if (load_acc && !clear) begin
      prescale_q <= prescale;
    end
  end

  // Held at zero throughout LOADED so RUN entry always starts a fresh period;
  // disabled on a stop cycle so a pause never swallows a pending tick.
  timer_prescaler #(.PW(PW)) u_prescaler (
    .clk  (clk),
    .rst_ (rst_),
    .en   ((state_q == RUN) && !stop && !clear),
    .clr  (clear || load_acc || (state_q == LOADED)),
    .div  (prescale_q),
    .tick (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    reload_d    = reload_q;
    periodic_d  = periodic_q;
    expired_d   = 1'b0;
    if (clear) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else if (load_acc) begin
      state_d     = LOADED;
      remaining_d = load_value;
      reload_d    = load_value;
      periodic_d  = load_periodic;
    end else begin
      unique case (state_q)
        LOADED, PAUSE: begin
          if (start && !stop) state_d = RUN;
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (tick) begin
            // A count of 0 or 1 expires on this tick; never wraps below zero.
            if (remaining_q <= W'(1)) begin
              expired_d = 1'b1;
              if (periodic_q) begin
                remaining_d = reload_q;
              end else begin
                remaining_d = '0;
                state_d     = IDLE;
              end
            end else begin
              remaining_d = remaining_q - W'(1);
            end
          end
        end
        default: ;
      endcase
    end
    irq_d = expired_d || (irq && !irq_ack);
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      reload_q    <= '0;
      periodic_q  <= 1'b0;
      expired     <= 1'b0;
      irq         <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      reload_q    <= reload_d;
      periodic_q  <= periodic_d;
      expired     <= expired_d;
      irq         <= irq_d;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed vector table plus hand-written multi-cycle sequences.
module tb_countdown_timer;

  localparam int unsigned W = 24;

  logic         clk = 1'b0;
  logic         rst_;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_value;
  logic         load_periodic;
  logic         start;
  logic         stop;
  logic         clear;
  logic         irq_ack;
  logic [W-1:0] remaining;
  logic         busy;
  logic         expired;
  logic         irq;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  countdown_timer #(.W(W), .PRESCALE_MAX(256)) dut (
    .clk           (clk),
    .rst_          (rst_),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_value    (load_value),
    .load_periodic (load_periodic),
    .start         (start),
    .stop          (stop),
    .clear         (clear),
    .irq_ack       (irq_ack),
    .remaining     (remaining),
    .busy          (busy),
    .expired       (expired),
    .irq           (irq)
`ifdef TIMER_PRESCALE_EN
    ,
    .prescale      (8'd0)
`endif
  );

  typedef struct {
    string        nm;
    bit           rst_;
    bit           lv;
    logic [W-1:0] val;
    bit           per;
    bit           st;
    bit           sp;
    bit           cl;
    bit           ak;
    logic [W-1:0] e_rem;
    bit           e_busy;
    bit           e_exp;
    bit           e_irq;
    bit           e_lr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string nm, bit r, bit lv, int val, bit per, bit st, bit sp,
                              bit cl, bit ak, int rem, bit bz, bit ex, bit iq, bit lr);
    vec_t v;
    v.nm = nm; v.rst_ = r; v.lv = lv; v.val = W'(val); v.per = per;
    v.st = st; v.sp = sp; v.cl = cl; v.ak = ak;
    v.e_rem = W'(rem); v.e_busy = bz; v.e_exp = ex; v.e_irq = iq; v.e_lr = lr;
    vecs.push_back(v);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(bit r, bit lv, logic [W-1:0] val, bit per, bit st, bit sp, bit cl, bit ak);
    rst_ = r; load_valid = lv; load_value = val; load_periodic = per;
    start = st; stop = sp; clear = cl; irq_ack = ak;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string nm, int rem, bit bz, bit ex, bit iq, bit lr);
    check({nm, ".remaining"}, 32'(remaining), 32'(rem));
    check({nm, ".busy"}, 32'(busy), 32'(bz));
    check({nm, ".expired"}, 32'(expired), 32'(ex));
    check({nm, ".irq"}, 32'(irq), 32'(iq));
    check({nm, ".load_ready"}, 32'(load_ready), 32'(lr));
  endtask

  initial begin
    int n;
    drive(1'b0, 0, '0, 0, 0, 0, 0, 0);

    //   name        rst lv val per st sp cl ak | rem bz ex iq lr
    add("reset",       0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
    add("idle",        1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
    // one-shot 5
    add("os_load",     1, 1, 5, 0, 0, 0, 0, 0,   5, 0, 0, 0, 1);
    add("os_start",    1, 0, 0, 0, 1, 0, 0, 0,   5, 1, 0, 0, 0);
    add("os_t1",       1, 0, 0, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0);
    add("os_t2",       1, 0, 0, 0, 0, 0, 0, 0,   3, 1, 0, 0, 0);
    add("os_t3",       1, 0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0);
    add("os_t4",       1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    add("os_exp",      1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1);
    add("os_after",    1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1);
    add("os_ack",      1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1);
    // periodic 3, ack coincident with expiry, stop on expiry tick
    add("pe_load",     1, 1, 3, 1, 0, 0, 0, 0,   3, 0, 0, 0, 1);
    add("pe_start",    1, 0, 0, 0, 1, 0, 0, 0,   3, 1, 0, 0, 0);
    add("pe_t1",       1, 0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0);
    add("pe_t2",       1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    add("pe_exp1",     1, 0, 0, 0, 0, 0, 0, 0,   3, 1, 1, 1, 0);
    add("pe_t4",       1, 0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 1, 0);
    add("pe_t5",       1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 1, 0);
    add("pe_exp_ack",  1, 0, 0, 0, 0, 0, 0, 1,   3, 1, 1, 1, 0);
    add("pe_ack",      1, 0, 0, 0, 0, 0, 0, 1,   2, 1, 0, 0, 0);
    add("pe_t8",       1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    add("pe_stop_exp", 1, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 0, 1);
    add("pe_st_sp",    1, 0, 0, 0, 1, 1, 0, 0,   1, 0, 0, 0, 1);
    add("pe_clear",    1, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1);
    // load 10, pause 6 cycles, resume
    add("pa_load",     1, 1, 10, 0, 0, 0, 0, 0, 10, 0, 0, 0, 1);
    add("pa_start",    1, 0, 0, 0, 1, 0, 0, 0,  10, 1, 0, 0, 0);
    add("pa_t1",       1, 0, 0, 0, 0, 0, 0, 0,   9, 1, 0, 0, 0);
    add("pa_t2",       1, 0, 0, 0, 0, 0, 0, 0,   8, 1, 0, 0, 0);
    add("pa_t3",       1, 0, 0, 0, 0, 0, 0, 0,   7, 1, 0, 0, 0);
    add("pa_t4",       1, 0, 0, 0, 0, 0, 0, 0,   6, 1, 0, 0, 0);
    add("pa_stop",     1, 0, 0, 0, 0, 1, 0, 0,   6, 0, 0, 0, 1);
    add("pa_hold1",    1, 0, 0, 0, 0, 0, 0, 0,   6, 0, 0, 0, 1);
    add("pa_hold2",    1, 0, 0, 0, 0, 0, 0, 0,   6, 0, 0, 0, 1);
    add("pa_hold3",    1, 0, 0, 0, 0, 0, 0, 0,   6, 0, 0, 0, 1);
    add("pa_hold4",    1, 0, 0, 0, 0, 0, 0, 0,   6, 0, 0, 0, 1);
    add("pa_hold5",    1, 0, 0, 0, 0, 0, 0, 0,   6, 0, 0, 0, 1);
    add("pa_resume",   1, 0, 0, 0, 1, 0, 0, 0,   6, 1, 0, 0, 0);
    add("pa_t5",       1, 0, 0, 0, 0, 0, 0, 0,   5, 1, 0, 0, 0);
    add("pa_t6",       1, 0, 0, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0);
    add("pa_t7",       1, 0, 0, 0, 0, 0, 0, 0,   3, 1, 0, 0, 0);
    add("pa_t8",       1, 0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0);
    add("pa_t9",       1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    add("pa_exp",      1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1);
    // load refused in RUN, clear mid-run keeps irq, reset mid-run
    add("rl_load",     1, 1, 7, 0, 0, 0, 0, 0,   7, 0, 0, 1, 1);
    add("rl_start",    1, 0, 0, 0, 1, 0, 0, 0,   7, 1, 0, 1, 0);
    add("rl_refused",  1, 1, 2, 0, 0, 0, 0, 0,   6, 1, 0, 1, 0);
    add("rl_t2",       1, 0, 0, 0, 0, 0, 0, 0,   5, 1, 0, 1, 0);
    add("rl_clear",    1, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 1);
    add("rs_load",     1, 1, 9, 0, 0, 0, 0, 0,   9, 0, 0, 1, 1);
    add("rs_start",    1, 0, 0, 0, 1, 0, 0, 0,   9, 1, 0, 1, 0);
    add("rs_t1",       1, 0, 0, 0, 0, 0, 0, 0,   8, 1, 0, 1, 0);
    add("rs_reset",    0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
    // load_value 0 expires on first tick
    add("z_load",      1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
    add("z_start",     1, 0, 0, 0, 1, 0, 0, 0,   0, 1, 0, 0, 0);
    add("z_exp",       1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1);
    // clear beats load and suppresses expiry
    add("cl_load",     1, 1, 2, 1, 0, 0, 0, 1,   2, 0, 0, 0, 1);
    add("cl_start",    1, 0, 0, 0, 1, 0, 0, 0,   2, 1, 0, 0, 0);
    add("cl_t1",       1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    add("cl_exp",      1, 0, 0, 0, 0, 0, 0, 0,   2, 1, 1, 1, 0);
    add("cl_clr_ld",   1, 1, 5, 0, 0, 0, 1, 0,   0, 0, 0, 1, 1);
    // start&stop in LOADED stays; stop in RUN has no tick
    add("ss_load",     1, 1, 4, 0, 0, 0, 0, 0,   4, 0, 0, 1, 1);
    add("ss_both",     1, 0, 0, 0, 1, 1, 0, 0,   4, 0, 0, 1, 1);
    add("ss_start",    1, 0, 0, 0, 1, 0, 0, 0,   4, 1, 0, 1, 0);
    add("ss_stop",     1, 0, 0, 0, 0, 1, 0, 0,   4, 0, 0, 1, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_, vecs[i].lv, vecs[i].val, vecs[i].per,
            vecs[i].st, vecs[i].sp, vecs[i].cl, vecs[i].ak);
      step();
      check_all(vecs[i].nm, int'(vecs[i].e_rem), vecs[i].e_busy, vecs[i].e_exp,
                vecs[i].e_irq, vecs[i].e_lr);
    end

    // Periodic reload of 1: expired high every cycle with no gap.
    drive(1, 0, '0, 0, 0, 0, 1, 1); step();
    drive(1, 1, W'(1), 1, 0, 0, 0, 0); step();
    drive(1, 0, '0, 0, 1, 0, 0, 0); step();
    check_all("p1_start", 1, 1, 0, 0, 0);
    drive(1, 0, '0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_all($sformatf("p1_cyc%0d", k), 1, 1, 1, 1, 0);
    end

    // One-shot 6: measure cycles from RUN entry to expired, bounded wait.
    drive(1, 0, '0, 0, 0, 0, 1, 1); step();
    drive(1, 1, W'(6), 0, 0, 0, 0, 0); step();
    drive(1, 0, '0, 0, 1, 0, 0, 0); step();
    drive(1, 0, '0, 0, 0, 0, 0, 0);
    n = 1;
    while (n <= 50) begin
      step();
      if (expired) break;
      n++;
    end
    check("lat6.cycles", 32'(n), 32'd6);
    check_all("lat6_end", 0, 0, 1, 1, 1);
    step();
    check("lat6.pulse_end", 32'(expired), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
